core_ctrl: RTL and testbench

Instruction sequencer that drives the 39-bit `inst` bus of the core for one kernel position (kij) per run. It loads one weight tile from activation/weight SRAM into the array via L0, streams `len_nij` activation vectors through it, then drains the OFIFO into the psum SRAM. It sits between the host/testbench and the core. It replaces hand-written testbench instruction sequences and is the initiator side of the `inst` / `ofifo_valid` interface.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/core_ctrl_xmem_to_l0.sv | 36 +++
 rtl/core_ctrl.sv | 174 +++++++++++++++++
 tb/tb_core_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: inst field map, idle word and sequencer state encoding shared by the
// core controller and its xmem-to-L0 sub-sequencer.
package core_pkg;

  localparam int INST_W       = 39;

  localparam int ROW_DEF      = 8;
  localparam int COL_DEF      = 8;
  localparam int LEN_NIJ_DEF  = 36;
  localparam int XA_BW_DEF    = 11;
  localparam int PA_BW_DEF    = 14;

  localparam int CEN_PMEM_BIT = 35;
  localparam int WEN_PMEM_BIT = 34;
  localparam int A_PMEM_LSB   = 20;
  localparam int CEN_XMEM_BIT = 19;
  localparam int WEN_XMEM_BIT = 18;
  localparam int A_XMEM_LSB   = 7;
  localparam int OFIFO_RD_BIT = 6;
  localparam int L0_RD_BIT    = 3;
  localparam int L0_WR_BIT    = 2;
  localparam int EXECUTE_BIT  = 1;
  localparam int LOAD_BIT     = 0;

  // Both SRAMs deselected (active-low enables high), every strobe low.
  localparam logic [INST_W-1:0] IDLE_WORD =
      (INST_W'(1) << CEN_PMEM_BIT) | (INST_W'(1) << WEN_PMEM_BIT) |
      (INST_W'(1) << CEN_XMEM_BIT) | (INST_W'(1) << WEN_XMEM_BIT);

  typedef enum logic [3:0] {
    IDLE,
    KREAD,
    KLOAD,
    KWAIT,
    AREAD,
    EXEC,
    DRAIN,
    OUTW,
    DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W_DEF = $clog2(max3(LEN_NIJ_DEF, ROW_DEF, COL_DEF) + 1);

endpackage

// File: rtl/core_ctrl_xmem_to_l0.sv
// xmem_to_l0: reads `count` consecutive xmem vectors from `base` and raises l0_wr
// one cycle after each read to absorb the SRAM read latency; lasts count+1 cycles.
module xmem_to_l0 import core_pkg::*; #(
  parameter int addr_w = XA_BW_DEF,
  parameter int cnt_w  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic [cnt_w-1:0]  count,
  input  logic [addr_w-1:0] base,
  output logic              xmem_rd,
  output logic [addr_w-1:0] xmem_addr,
  output logic              l0_wr,
  output logic              last
);

  logic [cnt_w-1:0] cnt;

  // Counter rests at zero whenever the owning state is not active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (!last) begin
      cnt <= cnt + cnt_w'(1);
    end
  end

  assign last      = (cnt == count);
  assign xmem_rd   = active && (cnt != count);
  assign l0_wr     = active && (cnt != '0);
  assign xmem_addr = base + addr_w'(cnt);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: per-kij instruction sequencer; loads a weight tile, streams activations
// and drains the OFIFO into psum memory, emitting a registered 39-bit inst word.
module core_ctrl import core_pkg::*; #(
  parameter int row     = ROW_DEF,
  parameter int col     = COL_DEF,
  parameter int len_nij = LEN_NIJ_DEF,
  parameter int xa_bw   = XA_BW_DEF,
  parameter int pa_bw   = PA_BW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [xa_bw-1:0]  w_base,
  input  logic [xa_bw-1:0]  a_base,
  input  logic [pa_bw-1:0]  p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(len_nij, row, col) + 1);
  localparam logic [CNT_W-1:0] ROW_CNT  = CNT_W'(row);
  localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(len_nij);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(len_nij - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt, wr_cnt_d;
  logic              pend, pend_d;
  logic [xa_bw-1:0]  w_q, w_d, a_q, a_d;
  logic [pa_bw-1:0]  p_q, p_d;
  logic [INST_W-1:0] inst_d;

  logic              seq_active;
  logic [CNT_W-1:0]  seq_count;
  logic [xa_bw-1:0]  seq_base;
  logic              seq_rd, seq_wr, seq_last;
  logic [xa_bw-1:0]  seq_addr;

  assign seq_active = (state == KREAD) || (state == AREAD);
  assign seq_count  = (state == AREAD) ? LEN_CNT : ROW_CNT;
  assign seq_base   = (state == AREAD) ? a_q : w_q;

  xmem_to_l0 #(
    .addr_w (xa_bw),
    .cnt_w  (CNT_W)
  ) u_xmem_to_l0 (
    .clk       (clk),
    .reset     (reset),
    .active    (seq_active),
    .count     (seq_count),
    .base      (seq_base),
    .xmem_rd   (seq_rd),
    .xmem_addr (seq_addr),
    .l0_wr     (seq_wr),
    .last      (seq_last)
  );

  assign busy = (state != IDLE);

  // inst_d is the word for the current cycle; it reaches the bus one edge later.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rd_cnt_d = rd_cnt;
    wr_cnt_d = wr_cnt;
    pend_d   = 1'b0;
    w_d      = w_q;
    a_d      = a_q;
    p_d      = p_q;
    inst_d   = IDLE_WORD;

    case (state)
      IDLE: begin
        cnt_d    = '0;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        if (start) begin
          w_d     = w_base;
          a_d     = a_base;
          p_d     = p_base;
          state_d = KREAD;
        end
      end
      KREAD, AREAD: begin
        inst_d[CEN_XMEM_BIT] = ~seq_rd;
        if (seq_rd) inst_d[A_XMEM_LSB +: xa_bw] = seq_addr;
        inst_d[L0_WR_BIT] = seq_wr;
        if (seq_last) state_d = (state == KREAD) ? KLOAD : EXEC;
      end
      KLOAD: begin
        inst_d[L0_RD_BIT] = 1'b1;
        inst_d[LOAD_BIT]  = 1'b1;
        cnt_d = cnt + CNT_W'(1);
        if (cnt == COL_LAST) begin
          cnt_d   = '0;
          state_d = KWAIT;
        end
      end
      KWAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == ROW_LAST) begin
          cnt_d   = '0;
          state_d = AREAD;
        end
      end
      EXEC: begin
        inst_d[L0_RD_BIT]   = 1'b1;
        inst_d[EXECUTE_BIT] = 1'b1;
        cnt_d = cnt + CNT_W'(1);
        if (cnt == LEN_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ofifo_valid) state_d = OUTW;
      end
      OUTW: begin
        if (ofifo_valid && (rd_cnt != LEN_CNT)) begin
          inst_d[OFIFO_RD_BIT] = 1'b1;
          rd_cnt_d = rd_cnt + CNT_W'(1);
          pend_d   = 1'b1;
        end
        // A read issued last cycle always retires as a write, even if valid dropped.
        if (pend) begin
          inst_d[CEN_PMEM_BIT] = 1'b0;
          inst_d[WEN_PMEM_BIT] = 1'b0;
          inst_d[A_PMEM_LSB +: pa_bw] = p_q + pa_bw'(wr_cnt);
          wr_cnt_d = wr_cnt + CNT_W'(1);
          if (wr_cnt == LEN_LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, run context and the registered inst/done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      pend   <= 1'b0;
      w_q    <= '0;
      a_q    <= '0;
      p_q    <= '0;
      inst   <= IDLE_WORD;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rd_cnt <= rd_cnt_d;
      wr_cnt <= wr_cnt_d;
      pend   <= pend_d;
      w_q    <= w_d;
      a_q    <= a_d;
      p_q    <= p_d;
      inst   <= inst_d;
      done   <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: randomized core_ctrl runs; a run-level model queues expected xmem
// reads, pmem writes and done timing, and a monitor compares them as they appear.
module tb_core_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LEN = 36;
  localparam logic [38:0] IDLE_WORD = 39'h0C000C0000;
  // Whole run in cycles, counting the start cycle and the done cycle.
  localparam int RUN_LEN = 1 + (ROW + 1) + COL + ROW + (LEN + 1) + LEN + 1 + (LEN + 1) + 1;
  // Cycle index (0 = first cycle after the start edge) of the done pulse.
  localparam int DONE_K  = RUN_LEN - 2;
  // First OUTW cycle with ofifo_valid already high, and the one deciding read t=10.
  localparam int OUTW_K  = (ROW + 1) + COL + ROW + (LEN + 1) + LEN + 1;
  localparam int STALL_K = OUTW_K + 10;
  localparam int EXEC_K  = (ROW + 1) + COL + ROW + (LEN + 1);

  logic        clk;
  logic        reset;
  logic        start;
  logic [10:0] w_base, a_base;
  logic [13:0] p_base;
  logic        ofifo_valid;
  logic [38:0] inst;
  logic        busy;
  logic        done;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .a_base      (a_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] exp_x[$];
  logic [13:0] exp_p[$];
  int          exp_done[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int runs = 0;
  int n_ofrd = 0, n_l0wr = 0, n_l0rd = 0, n_load = 0, n_exec = 0, n_resv = 0;
  logic valid_q = 1'b1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input longint act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) valid_q <= ofifo_valid;

  // Monitor: consume expectations whenever the bus shows an SRAM access or done.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      exp_x.delete();
      exp_p.delete();
      exp_done.delete();
      n_ofrd = 0; n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_resv = 0;
    end else begin
      if (!inst[19]) begin
        if (exp_x.size() == 0) flagFail("xmem_unexpected", inst[17:7]);
        else checkOutput("xmem_addr", inst[17:7], exp_x.pop_front());
        checkOutput("xmem_wen", inst[18], 1);
      end
      if (!inst[35]) begin
        if (exp_p.size() == 0) flagFail("pmem_unexpected", inst[33:20]);
        else checkOutput("pmem_addr", inst[33:20], exp_p.pop_front());
        checkOutput("pmem_wen", inst[34], 0);
      end
      if (inst[6]) begin
        n_ofrd++;
        if (!valid_q) flagFail("ofifo_rd_without_valid", inst);
      end
      if (inst[2]) n_l0wr++;
      if (inst[3]) n_l0rd++;
      if (inst[0]) n_load++;
      if (inst[1]) n_exec++;
      if (inst[38:36] != 3'b0 || inst[5:4] != 2'b0) n_resv++;
      if (done) begin
        if (exp_done.size() == 0) flagFail("done_unexpected", cyc);
        else begin
          checkOutput("done_cycle", cyc, exp_done.pop_front());
          checkOutput("busy_at_done", busy, 1);
          checkOutput("ofifo_rd_count", n_ofrd, LEN);
          checkOutput("l0_wr_count", n_l0wr, ROW + LEN);
          checkOutput("l0_rd_count", n_l0rd, COL + LEN);
          checkOutput("load_count", n_load, COL);
          checkOutput("execute_count", n_exec, LEN);
          checkOutput("reserved_bits", n_resv, 0);
          checkOutput("xmem_reads_left", exp_x.size(), 0);
          checkOutput("pmem_writes_left", exp_p.size(), 0);
        end
        done_cnt++;
        n_ofrd = 0; n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_resv = 0;
      end
    end
  end

  task automatic pushExpected(input logic [10:0] w, input logic [10:0] a,
                              input logic [13:0] p, input bit with_pmem);
    for (int i = 0; i < ROW; i++) exp_x.push_back(11'((int'(w) + i) % 2048));
    for (int t = 0; t < LEN; t++) exp_x.push_back(11'((int'(a) + t) % 2048));
    if (with_pmem)
      for (int t = 0; t < LEN; t++) exp_p.push_back(14'((int'(p) + t) % 16384));
  endtask

  // One complete run; optional OUTW stall, stray start at cycle busy_k, start during done.
  task automatic applyStimulus(input logic [10:0] w, input logic [10:0] a,
                               input logic [13:0] p, input int stall,
                               input int busy_k, input bit start_at_done);
    int c0, k, target;
    @(negedge clk);
    w_base = w; a_base = a; p_base = p;
    start  = 1'b1;
    c0     = cyc + 1;
    pushExpected(w, a, p, 1'b1);
    exp_done.push_back(c0 + DONE_K + stall);
    runs++;
    target = done_cnt + 1;
    for (int n = 0; n < 400 && done_cnt < target; n++) begin
      @(negedge clk);
      k = cyc - c0;
      start = (k == busy_k) || (start_at_done && k == DONE_K + stall);
      if (stall > 0 && k == STALL_K) ofifo_valid = 1'b0;
      if (stall > 0 && k == STALL_K + stall) ofifo_valid = 1'b1;
    end
    if (done_cnt < target) flagFail("run_timeout", cyc - c0);
    @(negedge clk);
    start = 1'b0;
    ofifo_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busy_after_run", busy, 0);
    checkOutput("inst_after_run", inst, IDLE_WORD);
  endtask

  // Start a run, then assert reset in the middle of EXEC.
  task automatic abortRun(input logic [10:0] w, input logic [10:0] a, input logic [13:0] p);
    int c0;
    @(negedge clk);
    w_base = w; a_base = a; p_base = p;
    start  = 1'b1;
    c0     = cyc + 1;
    pushExpected(w, a, p, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && (cyc - c0) < EXEC_K + 8; n++) @(negedge clk);
    checkOutput("abort_in_exec", inst[1], 1);
    checkOutput("abort_xmem_consumed", exp_x.size(), 0);
    reset = 1'b0;
    #1;
    checkOutput("midrun_reset_inst", inst, IDLE_WORD);
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_done", done, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_hold_inst", inst, IDLE_WORD);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    w_base = '0; a_base = '0; p_base = '0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_inst", inst, IDLE_WORD);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] nominal run");
    applyStimulus(11'd0, 11'd64, 14'd0, 0, -1, 1'b0);
    $display("[TB] OFIFO stall of 5 cycles at t=10");
    applyStimulus(11'($urandom), 11'($urandom), 14'($urandom), 5, -1, 1'b0);
    $display("[TB] address wrap");
    applyStimulus(11'($urandom), 11'd2040, 14'd16380, 0, -1, 1'b0);
    $display("[TB] start while busy and start during done");
    applyStimulus(11'($urandom), 11'($urandom), 14'($urandom),
                  int'($urandom_range(1, 6)), EXEC_K + 18, 1'b1);
    $display("[TB] mid-run reset then clean run");
    abortRun(11'($urandom), 11'($urandom), 14'($urandom));
    applyStimulus(11'($urandom), 11'($urandom), 14'($urandom), 0, -1, 1'b0);
    $display("[TB] random runs");
    for (int r = 0; r < 2; r++)
      applyStimulus(11'($urandom), 11'($urandom), 14'($urandom),
                    int'($urandom_range(0, 6)), -1, 1'b0);

    checkOutput("done_count", done_cnt, runs);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
